scan_chain_sequencer: RTL and testbench

Sequencer for a chain of scan flip-flops with asynchronous set/reset, such as the mux-D scan cells with active-low reset and set. It takes a parallel test pattern and drives the chain in three phases: serial load with scan-enable asserted, a functional capture window, then serial unload. The unloaded chain state is returned as a parallel word. It sits between a test/debug register interface and one scan chain, and owns the chain's SE and SI pins.

---
 rtl/scan_chain_sequencer.sv | 113 +++++++++++
 tb/tb_scan_chain_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_sequencer.sv
// Load/capture/unload sequencer that owns SE/SI of one scan chain and returns the unloaded word.
// Define SCAN_SEQ_COMPARE_EN to latch exp_in and flag result != exp_in on mismatch.
module scan_chain_sequencer #(
  parameter int CHAIN_LEN  = 32,
  parameter int CAP_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pat_in,
  input  logic [CHAIN_LEN-1:0] exp_in,
  input  logic                 so,
  output logic                 se,
  output logic                 si,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] result,
  output logic                 mismatch,
  output logic [2:0]           state_dbg
);

  // Handshake: start is accepted only on an edge where the FSM is IDLE; busy is high
  // from that edge until the edge ending DONE; done pulses for the single DONE cycle.

  // Widened to at least 4 bits so the capture window also fits on very short chains.
  localparam int CW = ($clog2(CHAIN_LEN + 1) > 4) ? $clog2(CHAIN_LEN + 1) : 4;
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] LAST_CAP = CW'(CAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic [CHAIN_LEN-1:0]   sr;
  logic                   accept;
  logic                   phase_end;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (cnt == LAST_BIT) state_nxt = CAPTURE;
      CAPTURE: if (cnt == LAST_CAP) state_nxt = UNLOAD;
      UNLOAD:  if (cnt == LAST_BIT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = (state == IDLE) && start;
  assign phase_end = (state_nxt != state);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      cnt    <= '0;
      sr     <= '0;
      se     <= 1'b0;
      si     <= 1'b0;
      result <= '0;
    end else begin
      cnt <= (phase_end || state == IDLE) ? '0 : cnt + 1'b1;
      se  <= (state_nxt == LOAD) || (state_nxt == UNLOAD);
      si  <= 1'b0;
      if (accept) begin
        sr <= pat_in;
        si <= pat_in[CHAIN_LEN-1];
      end else if (state == LOAD) begin
        // sr still holds the unshifted bit that goes out after this edge
        sr <= {sr[CHAIN_LEN-2:0], 1'b0};
        if (state_nxt == LOAD) si <= sr[CHAIN_LEN-2];
      end else if (state == UNLOAD) begin
        sr <= {sr[CHAIN_LEN-2:0], so};
        if (phase_end) result <= {sr[CHAIN_LEN-2:0], so};
      end
    end
  end

`ifdef SCAN_SEQ_COMPARE_EN
  logic [CHAIN_LEN-1:0] exp_lat;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      exp_lat  <= '0;
      mismatch <= 1'b0;
    end else if (accept) begin
      exp_lat  <= exp_in;
      mismatch <= 1'b0;
    end else if (state == UNLOAD && phase_end) begin
      mismatch <= ({sr[CHAIN_LEN-2:0], so} != exp_lat);
    end
  end
`else
  logic unused_exp;
  assign unused_exp = ^exp_in;
  assign mismatch   = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_scan_chain_sequencer.sv
// Randomised scoreboard bench for scan_chain_sequencer driving a behavioural scan chain.
// Honours SCAN_SEQ_COMPARE_EN when computing the expected mismatch flag.
module tb_scan_chain_sequencer;

  localparam int N   = 8;
  localparam int CAP = 3;
  localparam int LAT = 2 * N + CAP;   // cycle index (after accept) of the DONE cycle

  logic         CLK = 1'b0;
  logic         RN;
  logic         start;
  logic [N-1:0] pat_in, exp_in;
  logic         so, se, si, busy, done, mismatch;
  logic [N-1:0] result;
  logic [2:0]   state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] exp_q[$];
  bit           mm_q[$];

  // functional behaviour of the chain when se is low: 0 hold, 1 load constant, 2 invert
  int           mode;
  logic [N-1:0] d_val;
  logic [N-1:0] chain_q;

  scan_chain_sequencer #(.CHAIN_LEN(N), .CAP_CYCLES(CAP)) dut (
    .CLK(CLK), .RN(RN), .start(start), .pat_in(pat_in), .exp_in(exp_in), .so(so),
    .se(se), .si(si), .busy(busy), .done(done), .result(result), .mismatch(mismatch),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  // behavioural chain: flop 0 nearest SI, so is flop N-1
  always @(posedge CLK) begin
    if (se) chain_q <= {chain_q[N-2:0], si};
    else begin
      case (mode)
        1:       chain_q <= d_val;
        2:       chain_q <= ~chain_q;
        default: chain_q <= chain_q;
      endcase
    end
  end
  assign so = chain_q[N-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] ref_result(input logic [N-1:0] pat, input int m,
                                              input logic [N-1:0] d);
    case (m)
      0:       return pat;
      1:       return d;
      default: return (CAP % 2 == 1) ? ~pat : pat;
    endcase
  endfunction

  // driver tasks
  task automatic launch(input logic [N-1:0] pat, input int m, input logic [N-1:0] d,
                        input bit exp_wrong);
    logic [N-1:0] r, e;
    @(posedge CLK); #1;
    r = ref_result(pat, m, d);
    e = exp_wrong ? (r ^ N'(1)) : r;
    mode   = m;
    d_val  = d;
    pat_in = pat;
    exp_in = e;
    start  = 1'b1;
    exp_q.push_back(r);
`ifdef SCAN_SEQ_COMPARE_EN
    mm_q.push_back(r != e);
`else
    mm_q.push_back(1'b0);
`endif
    @(posedge CLK); #1;
    start  = 1'b0;
    pat_in = N'($urandom);
    exp_in = N'($urandom);
  endtask

  task automatic run_cycles(input int upto, input int poke);
    for (int k = 1; k <= upto; k++) begin
      @(posedge CLK); #1;
      start = (k == poke);
      if (k == poke) pat_in = N'($urandom);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
      start = 1'b0;
    end
  endtask

  // monitor: expected se/si timeline per cycle, scoreboard pop on done
  int           j;
  bit           active = 1'b0;
  bit           pending = 1'b0;
  logic [N-1:0] mpat;
  logic [N-1:0] last_res = '0;
  bit           last_mm = 1'b0;

  always @(negedge CLK) begin
    logic e_se, e_si;
    logic [N-1:0] r;
    bit mm;
    if (!RN) begin
      active  = 1'b0;
      pending = 1'b0;
      exp_q.delete();
      mm_q.delete();
      last_res = '0;
      last_mm  = 1'b0;
    end else begin
      if (pending) begin
        active  = 1'b1;
        pending = 1'b0;
        j       = 0;
      end
      if (active) begin
        if (j == LAT) begin
          check("done_cycle", {60'd0, se, si, busy, done}, {60'd0, 4'b0011});
          if (exp_q.size() == 0) check("sb_empty", 64'd1, 64'd0);
          else begin
            r  = exp_q.pop_front();
            mm = mm_q.pop_front();
            check("result", 64'(result), 64'(r));
            check("mismatch", 64'(mismatch), 64'(mm));
            last_res = r;
            last_mm  = mm;
          end
          active = 1'b0;
        end else begin
          e_se = (j < N) || (j >= N + CAP);
          e_si = (j < N) ? mpat[N-1-j] : 1'b0;
          check("step", {60'd0, se, si, busy, done}, {60'd0, e_se, e_si, 2'b10});
          check("held", {55'd0, result, mismatch}, {55'd0, last_res, 1'b0});
          j++;
        end
      end else begin
        check("idle", {51'd0, se, si, busy, done, result, mismatch},
                      {51'd0, 4'b0000, last_res, last_mm});
        if (start) begin
          pending = 1'b1;
          mpat    = pat_in;
        end
      end
    end
  end

  initial begin
    int m, poke;
    RN = 1'b0; start = 1'b0; pat_in = '0; exp_in = '0;
    mode = 0; d_val = '0; chain_q = '0;
    #2;
    check("rst_vals", {52'd0, se, si, busy, done, result, mismatch, state_dbg},
                      {52'd0, 4'b0000, 8'h00, 1'b0, 3'd0});
    repeat (2) @(posedge CLK);
    #1 RN = 1'b1;

    launch(8'hA5, 0, 8'h00, 1'b0); run_cycles(LAT, 0);       // pass-through
    launch(8'hFF, 1, 8'h3C, 1'b0); run_cycles(LAT, 0);       // capture, compare equal
    launch(8'hFF, 1, 8'h3C, 1'b1); run_cycles(LAT, 3);       // exp 3D, start mid-LOAD
    launch(8'h5A, 2, 8'h00, 1'b0); run_cycles(LAT, LAT);     // start during DONE
    idle(2);
    launch(8'h81, 0, 8'h00, 1'b0); run_cycles(LAT, 0);       // back-to-back follows
    launch(8'h7E, 1, 8'hC3, 1'b0); run_cycles(LAT, 0);

    // reset right after unload edge 4
    launch(8'hC3, 0, 8'h00, 1'b0); run_cycles(N + CAP + 5, 0);
    RN = 1'b0;
    #1;
    check("rst_mid", {54'd0, se, busy, done, result}, 64'd0);
    check("rst_mm", 64'(mismatch), 64'd0);
    @(posedge CLK); #1 RN = 1'b1;
    idle(2);
    launch(8'h96, 0, 8'h00, 1'b0); run_cycles(LAT, 0);

    for (int t = 0; t < 12; t++) begin
      m    = $urandom_range(0, 2);
      poke = ($urandom_range(0, 3) == 0) ? $urandom_range(1, LAT) : 0;
      launch(N'($urandom), m, N'($urandom), $urandom_range(0, 1) == 1);
      run_cycles(LAT, poke);
      idle($urandom_range(0, 2));
    end

    idle(4);
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
